dem_tree_sequencer: RTL and testbench
=====================================

DEM_TREE_SEQUENCER -- requirements
Module: dem_tree_sequencer

Interface
REQ-001 SHALL have parameter TREE_LATENCY, default 3: cycles from root input register to leaf outputs (one per switching layer).
REQ-002 SHALL have parameter MAX_CODE, default 8: largest legal code (unit-element count of the 3-layer tree).
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port enable_i, input, 1: level request to run conversion.
REQ-006 SHALL have port flush_i, input, 1: one-cycle pulse requesting drain to idle.
REQ-007 SHALL have port code_i, input, INPUT_WIDTH: DAC input code.
REQ-008 SHALL have port code_valid_i, input, 1: code_i valid.
REQ-009 SHALL have port code_ready_o, output, 1: sequencer accepts code_i this cycle.
REQ-010 SHALL have port tree_x_o, output, INPUT_WIDTH: registered code driven to the tree root x_in_i.
REQ-011 SHALL have port out_valid_o, output, 1: leaf outputs correspond to an accepted code.
REQ-012 SHALL have port busy_o, output, 1: state is not IDLE.
REQ-013 SHALL have port ovf_o, output, 1: sticky, a code above MAX_CODE was saturated.
REQ-014 SHALL have port udf_o, output, 1: sticky, RUN cycle with no valid code.
REQ-015 SHALL have port sample_cnt_o, output, 16: count of out_valid_o cycles.

Function
REQ-016 SHALL implement FSM IDLE, FILL, RUN, FLUSH; busy_o = (state != IDLE).
REQ-017 IDLE -> FILL when enable_i=1 and flush_i=0; entry into FILL SHALL clear ovf_o, udf_o, sample_cnt_o.
REQ-018 FILL SHALL last exactly TREE_LATENCY cycles, then -> RUN.
REQ-019 FILL or RUN -> FLUSH when flush_i=1 or enable_i=0; flush_i SHALL take priority over enable_i.
REQ-020 FLUSH SHALL last exactly TREE_LATENCY cycles, then -> IDLE regardless of enable_i.
REQ-021 code_ready_o SHALL be 1 exactly in FILL and RUN; it depends on state only.
REQ-022 On a cycle with code_valid_i & code_ready_o, tree_x_o SHALL load min(code_i, MAX_CODE) at that edge; if code_i > MAX_CODE, ovf_o SHALL set.
REQ-023 In FILL/RUN with code_valid_i=0, tree_x_o SHALL load 0; in RUN udf_o SHALL also set (FILL does not set udf_o).
REQ-024 In IDLE and FLUSH, tree_x_o SHALL load 0.
REQ-025 A TREE_LATENCY-deep valid shift register SHALL record each load's acceptance; out_valid_o SHALL be its tail, rising TREE_LATENCY cycles after the accepting edge.
REQ-026 A code accepted in the same cycle as flush_i SHALL be accepted and SHALL still produce out_valid_o; FLUSH SHALL drain it.
REQ-027 sample_cnt_o SHALL increment on every cycle with out_valid_o=1 and wrap 0xFFFF -> 0x0000.
REQ-028 Sticky flags SHALL hold through FLUSH and IDLE until the next FILL entry.

Reset
REQ-029 When reset_i=0 at a clock edge, state SHALL go to IDLE and tree_x_o, out_valid_o, code_ready_o, busy_o, ovf_o, udf_o, sample_cnt_o and the valid pipeline SHALL all go to 0.
REQ-030 Reset mid-FILL/RUN/FLUSH SHALL discard in-flight valid bits; no out_valid_o SHALL follow reset deassertion until a new acceptance.

Structure
REQ-031 The IDLE/FILL/RUN/FLUSH state enum and the default MAX_CODE, TREE_LATENCY constants SHALL live in lib_switchblock_pkg alongside INPUT_WIDTH.
REQ-032 The valid pipeline SHALL be a sub-module dem_valid_pipe (parameter DEPTH, ports clk_i, reset_i, in_i, out_o); the FSM and datapath stay in dem_tree_sequencer.

Verification
REQ-033 Reset, then enable_i=1 and codes 5,3,8 valid back-to-back -> tree_x_o =5,3,8 on consecutive cycles; out_valid_o high for 3 cycles starting 3 cycles after first acceptance; sample_cnt_o=3.
REQ-034 In RUN, code_i=12 valid -> tree_x_o=8, ovf_o=1 and sticky through FLUSH/IDLE; next IDLE->FILL clears it.
REQ-035 In RUN, code_valid_i=0 for one cycle -> tree_x_o=0, udf_o=1, out_valid_o low exactly one cycle 3 cycles later.
REQ-036 flush_i with code 4 valid the same cycle -> code 4 loaded, state FLUSH for 3 cycles, out_valid_o pulses for code 4, then IDLE, code_ready_o=0.
REQ-037 Preload sample_cnt_o to 0xFFFE via 2^16-2 valid outputs, then 2 more -> sample_cnt_o=0x0000.
REQ-038 reset_i=0 mid-RUN with 3 codes in flight -> all outputs 0 next edge; no out_valid_o after release without new input.

Source files
------------

// File: rtl/dem_tree_sequencer_pkg.sv
// Shared constants, state encoding and code saturation helper for the
// thermometer-tree DEM sequencer.
package lib_switchblock_pkg;

   localparam int INPUT_WIDTH      = 4;
   localparam int DEF_MAX_CODE     = 8;
   localparam int DEF_TREE_LATENCY = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } seq_state_e;

   function automatic logic [INPUT_WIDTH-1:0] sat_code(
      input logic [INPUT_WIDTH-1:0] code,
      input logic [INPUT_WIDTH-1:0] max_code
   );
      return (code > max_code) ? max_code : code;
   endfunction

endpackage

// File: rtl/dem_tree_sequencer_if.sv
// Code handshake between the code source (master) and the sequencer (slave).
interface dem_tree_sequencer_if;
   import lib_switchblock_pkg::*;

   logic [INPUT_WIDTH-1:0] code_i;
   logic                   code_valid_i;
   logic                   code_ready_o;

   modport master (output code_i, output code_valid_i, input code_ready_o);
   modport slave  (input code_i, input code_valid_i, output code_ready_o);

endinterface

// File: rtl/dem_tree_sequencer_valid_pipe.sv
// Valid-bit shift register tracking accepted codes through the switching layers.
module dem_valid_pipe #(
   parameter int DEPTH = 3
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic in_i,
   output logic out_o
);

   logic [DEPTH-1:0] stage_r;

   // shift acceptance bits one layer per cycle
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         stage_r <= '0;
      end else begin
         stage_r[0] <= in_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign out_o = stage_r[DEPTH-1];

endmodule

// File: rtl/dem_tree_sequencer.sv
// Sequencer feeding saturated codes into a registered DEM switching tree and
// tracking which leaf outputs belong to accepted codes.
module dem_tree_sequencer
   import lib_switchblock_pkg::*;
#(
   parameter int TREE_LATENCY = DEF_TREE_LATENCY,
   parameter int MAX_CODE     = DEF_MAX_CODE
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   flush_i,
   dem_tree_sequencer_if.slave    code_bus,
   output logic [INPUT_WIDTH-1:0] tree_x_o,
   output logic                   out_valid_o,
   output logic                   busy_o,
   output logic                   ovf_o,
   output logic                   udf_o,
   output logic [15:0]            sample_cnt_o
);

   localparam int CNT_W = (TREE_LATENCY > 1) ? $clog2(TREE_LATENCY) : 1;
   localparam logic [INPUT_WIDTH-1:0] MAX_CODE_W = INPUT_WIDTH'(MAX_CODE);

   seq_state_e             state_r, next_state_s;
   logic [CNT_W-1:0]       phase_cnt_r;
   logic                   phase_done_s, active_s, accept_s, enter_fill_s;
   logic                   ready_next_s, busy_next_s;
   logic [INPUT_WIDTH-1:0] tree_x_r;
   logic                   root_valid_r, ready_r, busy_r, ovf_r, udf_r, pipe_out_s;
   logic [15:0]            sample_cnt_r;

   assign phase_done_s = (phase_cnt_r == CNT_W'(TREE_LATENCY - 1));
   assign active_s     = (state_r == ST_FILL) || (state_r == ST_RUN);
   assign accept_s     = active_s && code_bus.code_valid_i;
   assign enter_fill_s = (state_r == ST_IDLE) && (next_state_s == ST_FILL);

   // state register with per-phase cycle counter for FILL/FLUSH timing
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_r     <= ST_IDLE;
         phase_cnt_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (next_state_s != state_r) begin
            phase_cnt_r <= '0;
         end else if (!phase_done_s) begin
            phase_cnt_r <= phase_cnt_r + CNT_W'(1);
         end
      end
   end

   // next-state logic; flush beats enable, FLUSH ignores enable
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:  if (enable_i && !flush_i) next_state_s = ST_FILL;
                   else                      next_state_s = ST_IDLE;
         ST_FILL:  if (flush_i || !enable_i) next_state_s = ST_FLUSH;
                   else if (phase_done_s)    next_state_s = ST_RUN;
                   else                      next_state_s = ST_FILL;
         ST_RUN:   if (flush_i || !enable_i) next_state_s = ST_FLUSH;
                   else                      next_state_s = ST_RUN;
         ST_FLUSH: if (phase_done_s)         next_state_s = ST_IDLE;
                   else                      next_state_s = ST_FLUSH;
         default:                            next_state_s = ST_IDLE;
      endcase
   end

   // state decodes, registered below so they track state_r exactly
   always_comb begin
      ready_next_s = (next_state_s == ST_FILL) || (next_state_s == ST_RUN);
      busy_next_s  = (next_state_s != ST_IDLE);
   end

   // root register, sticky flags and output sample counter
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ready_r      <= 1'b0;
         busy_r       <= 1'b0;
         tree_x_r     <= '0;
         root_valid_r <= 1'b0;
         ovf_r        <= 1'b0;
         udf_r        <= 1'b0;
         sample_cnt_r <= 16'd0;
      end else begin
         ready_r      <= ready_next_s;
         busy_r       <= busy_next_s;
         root_valid_r <= accept_s;
         if (accept_s) begin
            tree_x_r <= sat_code(code_bus.code_i, MAX_CODE_W);
         end else begin
            tree_x_r <= '0;
         end
         if (enter_fill_s) begin
            ovf_r        <= 1'b0;
            udf_r        <= 1'b0;
            sample_cnt_r <= 16'd0;
         end else begin
            if (accept_s && (code_bus.code_i > MAX_CODE_W)) ovf_r <= 1'b1;
            if ((state_r == ST_RUN) && !code_bus.code_valid_i) udf_r <= 1'b1;
            if (pipe_out_s) sample_cnt_r <= sample_cnt_r + 16'd1;
         end
      end
   end

   // the root register is the first layer; the pipe covers the remaining delay
   dem_valid_pipe #(.DEPTH(TREE_LATENCY)) u_valid_pipe (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .in_i    (root_valid_r),
      .out_o   (pipe_out_s)
   );

   assign code_bus.code_ready_o = ready_r;
   assign tree_x_o              = tree_x_r;
   assign out_valid_o           = pipe_out_s;
   assign busy_o                = busy_r;
   assign ovf_o                 = ovf_r;
   assign udf_o                 = udf_r;
   assign sample_cnt_o          = sample_cnt_r;

endmodule

// File: tb/tb_dem_tree_sequencer.sv
// Directed bench for dem_tree_sequencer: handshake, saturation, underflow,
// flush draining, counter wrap and mid-run reset.
module tb_dem_tree_sequencer;
   import lib_switchblock_pkg::*;

   logic                   clk_i;
   logic                   reset_i;
   logic                   enable_i;
   logic                   flush_i;
   logic [INPUT_WIDTH-1:0] tree_x_o;
   logic                   out_valid_o;
   logic                   busy_o;
   logic                   ovf_o;
   logic                   udf_o;
   logic [15:0]            sample_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   dem_tree_sequencer_if code_bus ();

   dem_tree_sequencer dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .enable_i     (enable_i),
      .flush_i      (flush_i),
      .code_bus     (code_bus.slave),
      .tree_x_o     (tree_x_o),
      .out_valid_o  (out_valid_o),
      .busy_o       (busy_o),
      .ovf_o        (ovf_o),
      .udf_o        (udf_o),
      .sample_cnt_o (sample_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic en, input logic fl, input logic vld, input logic [3:0] code);
      enable_i              = en;
      flush_i               = fl;
      code_bus.code_valid_i = vld;
      code_bus.code_i       = code;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_tree"},  32'(tree_x_o), 32'd0);
      check_val({tag, "_ovld"},  32'(out_valid_o), 32'd0);
      check_val({tag, "_ready"}, 32'(code_bus.code_ready_o), 32'd0);
      check_val({tag, "_busy"},  32'(busy_o), 32'd0);
      check_val({tag, "_ovf"},   32'(ovf_o), 32'd0);
      check_val({tag, "_udf"},   32'(udf_o), 32'd0);
      check_val({tag, "_cnt"},   32'(sample_cnt_o), 32'd0);
   endtask

   initial begin
      reset_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();
      check_all_zero("reset");

      // back-to-back codes 5,3,8; enable drops with the last one
      reset_i = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      check_val("fill_busy",  32'(busy_o), 32'd1);
      check_val("fill_ready", 32'(code_bus.code_ready_o), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 4'd5); tick();
      check_val("b2b_x5", 32'(tree_x_o), 32'd5);
      drive(1'b1, 1'b0, 1'b1, 4'd3); tick();
      check_val("b2b_x3", 32'(tree_x_o), 32'd3);
      drive(1'b0, 1'b0, 1'b1, 4'd8); tick();
      check_val("b2b_x8",    32'(tree_x_o), 32'd8);
      check_val("b2b_ovld0", 32'(out_valid_o), 32'd0);
      check_val("b2b_ready", 32'(code_bus.code_ready_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0); tick();
      check_val("b2b_ovld1", 32'(out_valid_o), 32'd1);
      check_val("b2b_x0",    32'(tree_x_o), 32'd0);
      tick();
      check_val("b2b_ovld2", 32'(out_valid_o), 32'd1);
      tick();
      check_val("b2b_ovld3", 32'(out_valid_o), 32'd1);
      check_val("b2b_idle",  32'(busy_o), 32'd0);
      tick();
      check_val("b2b_ovld4", 32'(out_valid_o), 32'd0);
      check_val("b2b_cnt",   32'(sample_cnt_o), 32'd3);
      check_val("b2b_ovf",   32'(ovf_o), 32'd0);

      // saturation and underflow in RUN
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      repeat (4) tick();
      check_val("fill_no_udf", 32'(udf_o), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 4'd12); tick();
      check_val("sat_x",   32'(tree_x_o), 32'd8);
      check_val("sat_ovf", 32'(ovf_o), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 4'd2); tick();
      check_val("run_x2", 32'(tree_x_o), 32'd2);
      drive(1'b1, 1'b0, 1'b0, 4'd7); tick();
      check_val("udf_x0",  32'(tree_x_o), 32'd0);
      check_val("udf_set", 32'(udf_o), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 4'd1); tick();
      check_val("gap_ovld_a", 32'(out_valid_o), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 4'd0); tick();
      check_val("gap_ovld_b", 32'(out_valid_o), 32'd1);
      tick();
      check_val("gap_ovld_hole", 32'(out_valid_o), 32'd0);
      tick();
      check_val("gap_ovld_c", 32'(out_valid_o), 32'd1);
      tick();
      check_val("gap_ovld_end", 32'(out_valid_o), 32'd0);
      check_val("gap_idle",     32'(busy_o), 32'd0);
      check_val("gap_cnt",      32'(sample_cnt_o), 32'd3);
      repeat (3) tick();
      check_val("idle_ovf_sticky", 32'(ovf_o), 32'd1);
      check_val("idle_udf_sticky", 32'(udf_o), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 4'd0); tick();
      check_val("refill_ovf", 32'(ovf_o), 32'd0);
      check_val("refill_udf", 32'(udf_o), 32'd0);
      check_val("refill_cnt", 32'(sample_cnt_o), 32'd0);

      // flush arriving together with a valid code
      repeat (3) tick();
      drive(1'b1, 1'b1, 1'b1, 4'd4); tick();
      check_val("fl_x4",    32'(tree_x_o), 32'd4);
      check_val("fl_busy",  32'(busy_o), 32'd1);
      check_val("fl_ready", 32'(code_bus.code_ready_o), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd0); tick();
      check_val("fl_busy2", 32'(busy_o), 32'd1);
      check_val("fl_ovld2", 32'(out_valid_o), 32'd0);
      tick();
      check_val("fl_busy3", 32'(busy_o), 32'd1);
      tick();
      check_val("fl_idle",   32'(busy_o), 32'd0);
      check_val("fl_ovld",   32'(out_valid_o), 32'd1);
      check_val("fl_ready0", 32'(code_bus.code_ready_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0); tick();
      check_val("fl_ovld_end", 32'(out_valid_o), 32'd0);

      // reset with codes in flight, one of them saturating
      drive(1'b1, 1'b0, 1'b0, 4'd0); tick();
      drive(1'b1, 1'b0, 1'b1, 4'd9); tick();
      check_val("rst_pre_ovf", 32'(ovf_o), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 4'd2); tick();
      drive(1'b1, 1'b0, 1'b1, 4'd3); tick();
      reset_i = 1'b0;
      tick();
      check_all_zero("midrst");
      reset_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val($sformatf("post_rst_ovld%0d", i), 32'(out_valid_o), 32'd0);
      end

      // sample counter wrap
      drive(1'b1, 1'b0, 1'b1, 4'd1); tick();
      repeat (4 + 65534) tick();
      check_val("wrap_pre",  32'(sample_cnt_o), 32'hFFFE);
      tick();
      tick();
      check_val("wrap_zero", 32'(sample_cnt_o), 32'h0000);
      check_val("wrap_ovld", 32'(out_valid_o), 32'd1);
      check_val("wrap_udf",  32'(udf_o), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      repeat (6) tick();
      check_val("wrap_idle", 32'(busy_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
